// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, writeback FSM encoding and opcode helpers.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd3;
  localparam logic [4:0] OP_DIV  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8;
  localparam logic [4:0] OP_SRL  = 5'd9;
  localparam logic [4:0] OP_SRA  = 5'd10;
  localparam logic [4:0] OP_SLT  = 5'd11;
  localparam logic [4:0] OP_SLTU = 5'd12;
  localparam logic [4:0] OP_NOR  = 5'd13;
  localparam logic [4:0] OP_XNOR = 5'd14;
  localparam logic [4:0] OP_NOT  = 5'd15;

  typedef enum logic [1:0] {
    StIdle       = 2'd0,
    StSendSingle = 2'd1,
    StSendLo     = 2'd2,
    StSendHi     = 2'd3
  } wb_state_t;

  // True for opcodes whose 2*DATA_W result is written back as LO then HI.
  function automatic logic is_two_beat(input logic [4:0] op,
                                       input logic [4:0] mul_op = OP_MUL,
                                       input logic [4:0] div_op = OP_DIV);
    return (op == mul_op) || (op == div_op);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Zero/negative flag computation for the final writeback beat.
// Two-beat results: zero over HI and LO, sign from HI. Single-beat: LO only.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_lo,
  input  logic [DATA_W-1:0] i_hi,
  input  logic              i_two_beat,
  output logic              o_zero,
  output logic              o_neg
);

  // Select flag sources by result width.
  always_comb begin
    o_zero = (i_lo == '0);
    o_neg  = i_lo[DATA_W-1];
    if (i_two_beat) begin
      o_zero = (i_lo == '0) && (i_hi == '0);
      o_neg  = i_hi[DATA_W-1];
    end
  end

endmodule

// File: rtl/alu_result_writeback.sv
// ALU result writeback sequencer: holds one 2*DATA_W result and emits it as one
// beat (single-width ops) or LO-then-HI beats (MUL/DIV) with valid/ready on both sides.
// Optional flag generation is enabled by defining WB_FLAGS_EN.
module alu_result_writeback
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4,
  parameter logic [4:0]  MUL_OP = OP_MUL,
  parameter logic [4:0]  DIV_OP = OP_DIV
) (
  input  logic                i_clk,
  input  logic                i_clr,
  input  logic                i_res_valid,
  output logic                o_res_ready,
  input  logic [2*DATA_W-1:0] i_alu_c,
  input  logic [4:0]          i_alu_opcode,
  input  logic [REG_AW-1:0]   i_dest_reg,
  output logic                o_wb_valid,
  input  logic                i_wb_ready,
  output logic [DATA_W-1:0]   o_wb_data,
  output logic [REG_AW-1:0]   o_wb_reg,
  output logic                o_wb_lo,
  output logic                o_wb_hi,
  output logic                o_busy,
  output logic                o_flag_z,
  output logic                o_flag_n
);

  wb_state_t             r_state;
  wb_state_t             w_state_d;
  logic [2*DATA_W-1:0]   r_res;
  logic [REG_AW-1:0]     r_dest;
  logic [DATA_W-1:0]     r_wb_data;
  logic [DATA_W-1:0]     w_wb_data_d;
  logic [REG_AW-1:0]     r_wb_reg;
  logic [REG_AW-1:0]     w_wb_reg_d;
  logic                  w_accept;
  logic [2*DATA_W-1:0]   w_res_next;
  logic [REG_AW-1:0]     w_dest_next;

  // Opcode 0 and >15 are accepted but produce no beat.
  function automatic wb_state_t decode_op(input logic [4:0] op);
    if (is_two_beat(op, MUL_OP, DIV_OP)) begin
      return StSendLo;
    end else if ((op != 5'd0) && (op <= OP_NOT)) begin
      return StSendSingle;
    end else begin
      return StIdle;
    end
  endfunction

  assign o_wb_valid = (r_state != StIdle);
  assign o_busy     = (r_state != StIdle);
  assign o_wb_lo    = (r_state == StSendLo);
  assign o_wb_hi    = (r_state == StSendHi);
  assign o_wb_data  = r_wb_data;
  assign o_wb_reg   = r_wb_reg;

  // A final beat retiring this cycle frees the holding register for a new result.
  assign o_res_ready = (r_state == StIdle) ||
                       (((r_state == StSendSingle) || (r_state == StSendHi)) && i_wb_ready);
  assign w_accept    = i_res_valid && o_res_ready;
  assign w_res_next  = w_accept ? i_alu_c : r_res;
  assign w_dest_next = w_accept ? i_dest_reg : r_dest;

  // Next state and next registered beat contents.
  always_comb begin
    w_state_d   = r_state;
    w_wb_data_d = '0;
    w_wb_reg_d  = '0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_d = decode_op(i_alu_opcode);
      end
      StSendSingle, StSendHi: begin
        if (i_wb_ready) w_state_d = w_accept ? decode_op(i_alu_opcode) : StIdle;
      end
      StSendLo: begin
        if (i_wb_ready) w_state_d = StSendHi;
      end
      default: w_state_d = StIdle;
    endcase
    unique case (w_state_d)
      StSendSingle: begin
        w_wb_data_d = w_res_next[DATA_W-1:0];
        w_wb_reg_d  = w_dest_next;
      end
      StSendLo: w_wb_data_d = w_res_next[DATA_W-1:0];
      StSendHi: w_wb_data_d = w_res_next[2*DATA_W-1:DATA_W];
      default:  w_wb_data_d = '0;
    endcase
  end

  // State, holding register and registered beat outputs.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_state   <= StIdle;
      r_res     <= '0;
      r_dest    <= '0;
      r_wb_data <= '0;
      r_wb_reg  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_res  <= i_alu_c;
        r_dest <= i_dest_reg;
      end
      r_wb_data <= w_wb_data_d;
      r_wb_reg  <= w_wb_reg_d;
    end
  end

`ifdef WB_FLAGS_EN
  logic w_final_done;
  logic w_flag_z;
  logic w_flag_n;
  logic r_flag_z;
  logic r_flag_n;

  // r_res still holds the retiring result even if a new one loads this edge.
  assign w_final_done = i_wb_ready &&
                        ((r_state == StSendSingle) || (r_state == StSendHi));

  alu_flag_gen #(
    .DATA_W(DATA_W)
  ) u_flag_gen (
    .i_lo      (r_res[DATA_W-1:0]),
    .i_hi      (r_res[2*DATA_W-1:DATA_W]),
    .i_two_beat(r_state == StSendHi),
    .o_zero    (w_flag_z),
    .o_neg     (w_flag_n)
  );

  // Flags update on final-beat completion and hold otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else if (w_final_done) begin
      r_flag_z <= w_flag_z;
      r_flag_n <= w_flag_n;
    end
  end

  assign o_flag_z = r_flag_z;
  assign o_flag_n = r_flag_n;
`else
  assign o_flag_z = 1'b0;
  assign o_flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_writeback.sv
// Scoreboard bench for alu_result_writeback: expected beats are queued at drive time
// and popped when the DUT completes a beat.
module tb_alu_result_writeback;
  import alu_pkg::*;

`ifdef WB_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [3:0]  rg;
    logic        lo;
    logic        hi;
  } beat_t;

  logic        clk;
  logic        clr;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] alu_c;
  logic [4:0]  opcode;
  logic [3:0]  dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_reg;
  logic        wb_lo;
  logic        wb_hi;
  logic        busy;
  logic        flag_z;
  logic        flag_n;

  beat_t sb_q[$];
  int    n_checks;
  int    n_errors;
  int    waits;

  alu_result_writeback dut (
    .i_clk       (clk),
    .i_clr       (clr),
    .i_res_valid (res_valid),
    .o_res_ready (res_ready),
    .i_alu_c     (alu_c),
    .i_alu_opcode(opcode),
    .i_dest_reg  (dest),
    .o_wb_valid  (wb_valid),
    .i_wb_ready  (wb_ready),
    .o_wb_data   (wb_data),
    .o_wb_reg    (wb_reg),
    .o_wb_lo     (wb_lo),
    .o_wb_hi     (wb_hi),
    .o_busy      (busy),
    .o_flag_z    (flag_z),
    .o_flag_n    (flag_n)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Completed beats are compared against the scoreboard head.
  always @(negedge clk) begin
    beat_t e;
    if (clr && wb_valid && wb_ready) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("beat_data", {32'd0, wb_data}, {32'd0, e.data});
        check_val("beat_reg", {60'd0, wb_reg}, {60'd0, e.rg});
        check_val("beat_lo", {63'd0, wb_lo}, {63'd0, e.lo});
        check_val("beat_hi", {63'd0, wb_hi}, {63'd0, e.hi});
      end
    end
  end

  // Drive one result, queue its expected beats, wait for acceptance.
  task automatic send(input logic [63:0] c, input logic [4:0] op, input logic [3:0] dst);
    beat_t b;
    alu_c     = c;
    opcode    = op;
    dest      = dst;
    res_valid = 1'b1;
    if (op == 5'd3 || op == 5'd4) begin
      b.data = c[31:0];  b.rg = 4'd0; b.lo = 1'b1; b.hi = 1'b0; sb_q.push_back(b);
      b.data = c[63:32]; b.rg = 4'd0; b.lo = 1'b0; b.hi = 1'b1; sb_q.push_back(b);
    end else if (op >= 5'd1 && op <= 5'd15) begin
      b.data = c[31:0];  b.rg = dst;  b.lo = 1'b0; b.hi = 1'b0; sb_q.push_back(b);
    end
    waits = 0;
    @(negedge clk);
    while (!res_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!res_ready) check_val("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_val("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    clk       = 1'b0;
    clr       = 1'b0;
    res_valid = 1'b0;
    alu_c     = '0;
    opcode    = '0;
    dest      = '0;
    wb_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", {63'd0, wb_valid}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_data", {32'd0, wb_data}, 64'd0);
    check_val("rst_reg", {60'd0, wb_reg}, 64'd0);
    check_val("rst_lohi", {62'd0, wb_lo, wb_hi}, 64'd0);
    check_val("rst_flags", {62'd0, flag_z, flag_n}, 64'd0);
    check_val("rst_ready", {63'd0, res_ready}, 64'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;

    // ADD: single beat visible right after the accept edge
    send(64'h0000_0000_0000_0005, OP_ADD, 4'd3);
    check_val("add_valid", {63'd0, wb_valid}, 64'd1);
    check_val("add_data", {32'd0, wb_data}, 64'd5);
    check_val("add_reg", {60'd0, wb_reg}, 64'd3);
    @(posedge clk);
    #1;
    check_val("add_idle", {63'd0, busy}, 64'd0);
    check_val("add_flag_z", {63'd0, flag_z}, 64'd0);

    // MUL: LO beat then HI beat
    send(64'h0000_0001_8000_0000, OP_MUL, 4'd7);
    check_val("mul_lo_flag", {63'd0, wb_lo}, 64'd1);
    check_val("mul_lo_data", {32'd0, wb_data}, 64'h8000_0000);
    check_val("mul_lo_reg", {60'd0, wb_reg}, 64'd0);
    @(posedge clk);
    #1;
    check_val("mul_hi_flag", {63'd0, wb_hi}, 64'd1);
    check_val("mul_hi_data", {32'd0, wb_data}, 64'd1);
    @(posedge clk);
    #1;
    check_val("mul_idle", {63'd0, busy}, 64'd0);
    check_val("mul_flag_n", {63'd0, flag_n}, 64'd0);

    // Stall: DIV with wb_ready low for 4 cycles
    wb_ready = 1'b0;
    send(64'h1234_5678_9abc_def0, OP_DIV, 4'd2);
    repeat (4) begin
      @(negedge clk);
      check_val("stall_valid", {63'd0, wb_valid}, 64'd1);
      check_val("stall_lo", {63'd0, wb_lo}, 64'd1);
      check_val("stall_data", {32'd0, wb_data}, 64'h9abc_def0);
      check_val("stall_ready", {63'd0, res_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    wb_ready = 1'b1;
    wait_idle();

    // Back-to-back single-beat results: second accepted with no wait
    send(64'hDEAD_0000_0000_0011, OP_SUB, 4'd4);
    send(64'h0000_0000_0000_00F0, OP_AND, 4'd6);
    check_val("b2b_no_wait", 64'(waits), 64'd0);
    check_val("b2b_valid", {63'd0, wb_valid}, 64'd1);
    check_val("b2b_data", {32'd0, wb_data}, 64'hF0);
    check_val("b2b_reg", {60'd0, wb_reg}, 64'd6);
    wait_idle();

    // Discarded opcodes: accepted, no beat
    send(64'h55, 5'd0, 4'd1);
    check_val("disc0_idle", {63'd0, busy}, 64'd0);
    send(64'h66, 5'd20, 4'd1);
    check_val("disc20_idle", {63'd0, busy}, 64'd0);

    // Flags
    send(64'h0000_0000_FFFF_FFFF, OP_SUB, 4'd1);
    @(posedge clk);
    #1;
    check_val("flag_neg_n", {63'd0, flag_n}, {63'd0, FlagsOn});
    check_val("flag_neg_z", {63'd0, flag_z}, 64'd0);
    send(64'h0, OP_ADD, 4'd2);
    @(posedge clk);
    #1;
    check_val("flag_zero_z", {63'd0, flag_z}, {63'd0, FlagsOn});
    check_val("flag_zero_n", {63'd0, flag_n}, 64'd0);
    send(64'h0000_0001_0000_0000, OP_MUL, 4'd0);
    wait_idle();
    check_val("flag_mulhi_z", {63'd0, flag_z}, 64'd0);
    send(64'h8000_0000_0000_0000, OP_DIV, 4'd0);
    wait_idle();
    check_val("flag_divhi_n", {63'd0, flag_n}, {63'd0, FlagsOn});

    // Reset during SEND_HI drops the HI beat
    wb_ready = 1'b0;
    send(64'h0000_0002_0000_0001, OP_MUL, 4'd0);
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    check_val("rst_pre_hi", {63'd0, wb_hi}, 64'd1);
    clr = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    check_val("rst_mid_valid", {63'd0, wb_valid}, 64'd0);
    check_val("rst_mid_busy", {63'd0, busy}, 64'd0);
    check_val("rst_mid_data", {32'd0, wb_data}, 64'd0);
    check_val("rst_mid_flags", {62'd0, flag_z, flag_n}, 64'd0);
    clr = 1'b1;
    wb_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_no_hi", {63'd0, wb_valid}, 64'd0);

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
